// File: rtl/dump_pkg.sv
// Shared definitions for the BRAM-to-UART debug dump.
//   SYNC0/SYNC1 : packet sync bytes (not part of the checksum)
//   state_t     : top-level packet sequencer states
//   phase_t     : byte handshake phases inside uart_byte_issuer
//   hdr_byte    : byte n (0..3) of the packet header for a given count
package dump_pkg;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RD,
        S_RDW,
        S_SEND_HI,
        S_SEND_LO,
        S_CSUM,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_ISSUE,
        PH_ACK,
        PH_DRAIN
    } phase_t;

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] cnt);
        case (idx)
            2'd0:    hdr_byte = SYNC0;
            2'd1:    hdr_byte = SYNC1;
            2'd2:    hdr_byte = cnt[15:8];
            default: hdr_byte = cnt[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_byte_issuer.sv
// Hands one byte at a time to uart_tx using an issue / ack / drain sequence.
//   clk, reset  : clock, synchronous active-high reset
//   send        : a byte is offered on byte_in (taken only when free and tx_busy=0)
//   byte_in     : byte offered
//   tx_busy     : uart_tx busy flag
//   tx_dv       : one-cycle strobe to uart_tx
//   tx_byte     : held byte, stable until the next accepted send
//   byte_done   : one-cycle pulse when the drain sees tx_busy=0
//
// phase    | meaning
// PH_IDLE  | nothing in flight, waiting for send with tx_busy low
// PH_ISSUE | tx_dv high for this cycle
// PH_ACK   | fixed one-cycle wait while uart_tx raises tx_busy
// PH_DRAIN | wait for tx_busy to fall
module uart_byte_issuer
    import dump_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] byte_in,
    input  logic       tx_busy,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    output logic       byte_done
);

    phase_t phase;
    phase_t phase_n;
    logic   accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase   <= PH_IDLE;
            tx_byte <= 8'h00;
        end else begin
            phase <= phase_n;
            if (accept) begin
                tx_byte <= byte_in;
            end
        end
    end

    always_comb begin
        phase_n = phase;
        case (phase)
            PH_IDLE:  if (accept) phase_n = PH_ISSUE;
            PH_ISSUE: phase_n = PH_ACK;
            PH_ACK:   phase_n = PH_DRAIN;
            PH_DRAIN: if (!tx_busy) phase_n = accept ? PH_ISSUE : PH_IDLE;
            default:  phase_n = PH_IDLE;
        endcase
    end

    // A send offered in the drain-complete cycle chains straight into the next
    // issue, so back-to-back bytes cost exactly 2 + busy cycles.
    assign tx_dv     = (phase == PH_ISSUE);
    assign byte_done = (phase == PH_DRAIN) && !tx_busy;
    assign accept    = send && !tx_busy && ((phase == PH_IDLE) || (phase == PH_DRAIN));

endmodule

// File: rtl/bram_uart_dump.sv
// Streams a window of a synchronous-read BRAM out over UART as a framed packet:
// A5 5A CNT_HI CNT_LO {word_hi word_lo}* CSUM, CSUM = sum of CNT and data bytes.
//   clk, reset            : clock, synchronous active-high reset
//   start                 : pulse, accepted in IDLE only
//   base_addr, word_count : window start and length, sampled with start
//   mem_en, mem_addr      : BRAM read port request
//   mem_q                 : BRAM read data, one cycle after mem_en
//   tx_dv, tx_byte        : byte strobe and byte to uart_tx
//   tx_busy               : uart_tx busy flag
//   busy, done            : packet in progress, one-cycle completion pulse
//
// state     | meaning
// S_IDLE    | waiting for start
// S_HDR     | sending sync and count bytes (hdr_idx selects which)
// S_RD      | mem_en for one cycle at addr_q
// S_RDW     | mem_q valid: capture word, offer its high byte
// S_SEND_HI | high byte of word in flight
// S_SEND_LO | low byte of word in flight
// S_CSUM    | checksum byte in flight
// S_FIN     | done pulse
module bram_uart_dump
    import dump_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1568,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [15:0]           word_count,
    output logic                  mem_en,
    output logic [AW-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  tx_dv,
    output logic [7:0]            tx_byte,
    input  logic                  tx_busy,
    output logic                  busy,
    output logic                  done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] addr_q;
    logic [15:0]   cnt_q;
    logic [15:0]   words_left;
    logic [15:0]   word_q;
    logic [15:0]   q_ext;
    logic [7:0]    csum_q;
    logic [1:0]    hdr_idx;
    logic          send;
    logic [7:0]    byte_in;
    logic          byte_done;

    assign q_ext    = 16'($signed(mem_q));
    assign mem_addr = addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (start) state_n = S_HDR;
            S_HDR:     if (byte_done && hdr_idx == 2'd3) state_n = (cnt_q == 16'd0) ? S_CSUM : S_RD;
            S_RD:      state_n = S_RDW;
            S_RDW:     state_n = S_SEND_HI;
            S_SEND_HI: if (byte_done) state_n = S_SEND_LO;
            S_SEND_LO: if (byte_done) state_n = (words_left != 16'd0) ? S_RD : S_CSUM;
            S_CSUM:    if (byte_done) state_n = S_FIN;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en = (state == S_RD);
        busy   = (state != S_IDLE) && (state != S_FIN);
        done   = (state == S_FIN);
    end

    // When a byte drains, the byte for the following position is offered in the
    // same cycle so the issuer can chain it. Otherwise the current position's
    // byte is offered; the issuer ignores it while a byte is still in flight.
    // tx_byte still holds the byte just drained, so the checksum lookahead
    // adds it before it lands in csum_q.
    always_comb begin
        send    = 1'b0;
        byte_in = 8'h00;
        if (byte_done) begin
            case (state)
                S_HDR: begin
                    if (hdr_idx != 2'd3) begin
                        send    = 1'b1;
                        byte_in = hdr_byte(hdr_idx + 2'd1, cnt_q);
                    end else if (cnt_q == 16'd0) begin
                        send    = 1'b1;
                        byte_in = csum_q + tx_byte;
                    end
                end
                S_SEND_HI: begin
                    send    = 1'b1;
                    byte_in = word_q[7:0];
                end
                S_SEND_LO: begin
                    if (words_left == 16'd0) begin
                        send    = 1'b1;
                        byte_in = csum_q + tx_byte;
                    end
                end
                default: ;
            endcase
        end else begin
            case (state)
                S_HDR:     begin send = 1'b1; byte_in = hdr_byte(hdr_idx, cnt_q); end
                S_RDW:     begin send = 1'b1; byte_in = q_ext[15:8];              end
                S_SEND_HI: begin send = 1'b1; byte_in = word_q[15:8];             end
                S_SEND_LO: begin send = 1'b1; byte_in = word_q[7:0];              end
                S_CSUM:    begin send = 1'b1; byte_in = csum_q;                   end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            cnt_q      <= 16'd0;
            words_left <= 16'd0;
            word_q     <= 16'd0;
            csum_q     <= 8'h00;
            hdr_idx    <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt_q      <= (int'(word_count) > DEPTH) ? 16'(DEPTH) : word_count;
                        words_left <= (int'(word_count) > DEPTH) ? 16'(DEPTH) : word_count;
                        addr_q     <= (int'(base_addr) >= DEPTH) ? base_addr - AW'(DEPTH) : base_addr;
                        csum_q     <= 8'h00;
                        hdr_idx    <= 2'd0;
                    end
                end
                S_HDR: begin
                    if (byte_done) begin
                        hdr_idx <= hdr_idx + 2'd1;
                        // sync bytes (idx 0,1) stay out of the checksum
                        if (hdr_idx[1]) csum_q <= csum_q + tx_byte;
                    end
                end
                S_RD: begin
                    words_left <= words_left - 16'd1;
                    addr_q     <= (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
                end
                S_RDW: begin
                    word_q <= q_ext;
                end
                S_SEND_HI, S_SEND_LO: begin
                    if (byte_done) csum_q <= csum_q + tx_byte;
                end
                default: ;
            endcase
        end
    end

    uart_byte_issuer u_issuer (
        .clk       (clk),
        .reset     (reset),
        .send      (send),
        .byte_in   (byte_in),
        .tx_busy   (tx_busy),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .byte_done (byte_done)
    );

endmodule

// File: tb/tb_bram_uart_dump.sv
module tb_bram_uart_dump;

    localparam int DW    = 12;
    localparam int DEPTH = 1568;
    localparam int AW    = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [15:0]   word_count;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_q = '0;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          tx_busy;
    logic          busy;
    logic          done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bram_uart_dump #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_q      (mem_q),
        .tx_dv      (tx_dv),
        .tx_byte    (tx_byte),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .done       (done)
    );

    // synchronous-read BRAM
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (mem_en) mem_q <= mem[mem_addr];

    // uart_tx model: busy rises the cycle after tx_dv and lasts blen cycles
    int   blen       = 1;
    int   bcnt       = 0;
    logic model_busy = 1'b0;
    logic hold_busy  = 1'b0;
    assign tx_busy = model_busy | hold_busy;

    always @(posedge clk) begin
        if (tx_dv) begin
            model_busy <= 1'b1;
            bcnt       <= blen;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else begin
            model_busy <= 1'b0;
            bcnt       <= 0;
        end
    end

    // monitors
    logic [7:0] byte_q [$];
    int         addr_log [$];
    int         done_cnt  = 0;
    int         stab_err  = 0;
    logic [7:0] last_byte = 8'h00;
    logic       armed     = 1'b0;

    always @(negedge clk) begin
        if (reset) armed = 1'b0;
        if (tx_dv) begin
            byte_q.push_back(tx_byte);
            last_byte = tx_byte;
            armed     = 1'b1;
        end else if (armed && tx_busy && tx_byte !== last_byte) begin
            stab_err++;
        end
        if (mem_en) addr_log.push_back(int'(mem_addr));
        if (done) done_cnt++;
    end

    task automatic check(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", nm, act, act, exp, exp);
    endtask

    task automatic clear_logs();
        @(posedge clk);
        byte_q.delete();
        addr_log.delete();
        done_cnt = 0;
        stab_err = 0;
    endtask

    // packet as described: sync, count, sign-extended words, checksum
    task automatic build_expected(input int base, input int cnt, output logic [7:0] e [$]);
        int         n;
        int         a;
        logic [15:0] w;
        logic [7:0]  cs;
        e.delete();
        n  = (cnt > DEPTH) ? DEPTH : cnt;
        a  = (base >= DEPTH) ? base - DEPTH : base;
        cs = 8'(n >> 8) + 8'(n);
        e.push_back(8'hA5);
        e.push_back(8'h5A);
        e.push_back(8'(n >> 8));
        e.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = {{4{mem[a][DW-1]}}, mem[a]};
            e.push_back(w[15:8]);
            e.push_back(w[7:0]);
            cs = cs + w[15:8] + w[7:0];
            a  = (a == DEPTH - 1) ? 0 : a + 1;
        end
        e.push_back(cs);
    endtask

    task automatic check_packet(input string nm, input int base, input int cnt, input int exp_len,
                                input int exp_cnt, input int exp_csum, input int exp_reads,
                                input int a0, input int a1);
        logic [7:0] e [$];
        int diff;
        int n;
        int sz;
        build_expected(base, cnt, e);
        sz = byte_q.size();
        check({nm, ":len"}, sz, exp_len);
        n    = (sz < e.size()) ? sz : e.size();
        diff = -1;
        for (int i = n - 1; i >= 0; i--) if (byte_q[i] !== e[i]) diff = i;
        if (diff < 0 && sz != e.size()) diff = n;
        check({nm, ":first_bad_byte_idx"}, diff, -1);
        check({nm, ":cnt"}, (sz >= 4) ? int'({byte_q[2], byte_q[3]}) : -1, exp_cnt);
        check({nm, ":csum"}, (sz > 0) ? int'(byte_q[sz-1]) : -1, exp_csum);
        check({nm, ":reads"}, addr_log.size(), exp_reads);
        if (a0 >= 0) check({nm, ":addr0"}, (addr_log.size() > 0) ? addr_log[0] : -1, a0);
        if (a1 >= 0) check({nm, ":addr1"}, (addr_log.size() > 1) ? addr_log[1] : -1, a1);
        check({nm, ":done_pulses"}, done_cnt, 1);
        check({nm, ":tx_byte_unstable"}, stab_err, 0);
    endtask

    task automatic run_packet(input int base, input int cnt, input int bl, input int hold, input int limit);
        int cyc;
        clear_logs();
        @(negedge clk);
        blen       = bl;
        hold_busy  = (hold > 0);
        base_addr  = AW'(base);
        word_count = 16'(cnt);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (hold > 1) repeat (hold - 1) @(negedge clk);
        hold_busy = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < limit) begin
            @(posedge clk);
            cyc++;
        end
        repeat (6) @(posedge clk);
    endtask

    typedef struct {
        string nm;
        int base;
        int cnt;
        int bl;
        int hold;
        int exp_len;
        int exp_cnt;
        int exp_csum;
        int exp_reads;
        int a0;
        int a1;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int cyc;
        vecs[0] = '{"basic",      5,    2,    1,   0, 9,    2,    8'h84, 2,    5,    6};
        vecs[1] = '{"empty",      0,    0,    1,   0, 5,    0,    8'h00, 0,    -1,   -1};
        vecs[2] = '{"wrap",       1567, 2,    2,   0, 9,    2,    8'h00, 2,    1567, 0};
        vecs[3] = '{"base_over",  1573, 2,    1,   0, 9,    2,    8'h84, 2,    5,    6};
        vecs[4] = '{"slow_uart",  5,    2,    868, 0, 9,    2,    8'h84, 2,    5,    6};
        vecs[5] = '{"busy_start", 5,    2,    3,   10, 9,   2,    8'h84, 2,    5,    6};
        vecs[6] = '{"empty_slow", 0,    0,    868, 0, 5,    0,    8'h00, 0,    -1,   -1};
        vecs[7] = '{"clamp",      0,    2000, 1,   0, 3141, 1568, 8'hA6, 1568, 0,    1};

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[5]    = 12'h102;
        mem[6]    = 12'hF80;
        mem[1567] = 12'h800;
        mem[0]    = 12'h7FF;

        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = 16'd0;
        repeat (3) @(negedge clk);
        check("rst:tx_dv",    int'(tx_dv),    0);
        check("rst:tx_byte",  int'(tx_byte),  0);
        check("rst:mem_en",   int'(mem_en),   0);
        check("rst:mem_addr", int'(mem_addr), 0);
        check("rst:busy",     int'(busy),     0);
        check("rst:done",     int'(done),     0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // start latency, busy timing, done/busy overlap
        clear_logs();
        @(negedge clk);
        blen = 1; base_addr = 11'd5; word_count = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("lat:busy_c1",  int'(busy),  1);
        check("lat:tx_dv_c1", int'(tx_dv), 0);
        @(negedge clk);
        check("lat:tx_dv_c2", int'(tx_dv), 1);
        check("lat:byte0",    int'(tx_byte), 8'hA5);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("fin:done_seen",    int'(done), 1);
        check("fin:busy_at_done", int'(busy), 0);
        repeat (4) @(posedge clk);
        check_packet("lat_pkt", 5, 2, 9, 2, 8'h84, 2, 5, 6);

        // table-driven packets
        foreach (vecs[k]) begin
            run_packet(vecs[k].base, vecs[k].cnt, vecs[k].bl, vecs[k].hold, 20000);
            check_packet(vecs[k].nm, vecs[k].base, vecs[k].cnt, vecs[k].exp_len, vecs[k].exp_cnt,
                         vecs[k].exp_csum, vecs[k].exp_reads, vecs[k].a0, vecs[k].a1);
        end

        // second start mid-packet is ignored
        clear_logs();
        @(negedge clk);
        blen = 3; base_addr = 11'd5; word_count = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (byte_q.size() < 3 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        base_addr = 11'd0; word_count = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        repeat (20) @(posedge clk);
        check_packet("restart_ignored", 5, 2, 9, 2, 8'h84, 2, 5, 6);

        // reset after the fifth byte abandons the packet
        clear_logs();
        @(negedge clk);
        blen = 4; base_addr = 11'd5; word_count = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (byte_q.size() < 5 && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst:tx_dv",    int'(tx_dv),    0);
        check("midrst:tx_byte",  int'(tx_byte),  0);
        check("midrst:mem_en",   int'(mem_en),   0);
        check("midrst:mem_addr", int'(mem_addr), 0);
        check("midrst:busy",     int'(busy),     0);
        check("midrst:done",     int'(done),     0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        check("midrst:no_done",    done_cnt,      0);
        check("midrst:byte_count", byte_q.size(), 5);

        // clean packet after reset
        run_packet(5, 2, 2, 0, 2000);
        check_packet("after_reset", 5, 2, 9, 2, 8'h84, 2, 5, 6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
